gppm_pipe: RTL and testbench

- Parametrised, two-stage pipelined general-purpose processing module: register file, ALU and write-back select (ALU result or immediate).
- Replaces the single-cycle unit, whose clock is embedded in the instruction word, with a true clocked datapath.
- Adds a valid/ready instruction handshake, output backpressure, operand bypassing and a hard-wired zero register.
- Sits between the instruction sequencer (upstream) and result consumers (downstream).

---
 rtl/gppm_pipe.sv | 133 +++++++++++++
 tb/tb_gppm_pipe.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/gppm_pipe.sv
// Two-stage pipelined processing unit: register file, ALU, write-back select.
// Ports: clk/rst, instr_* handshake + fields, out_valid/out_ready, gppm_out, isZero.
module gppm_pipe #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32,
  localparam int AW = $clog2(REG_CNT),
  localparam int SW = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     ra2,
  input  logic [AW-1:0]     wa,
  input  logic [3:0]        operation,
  input  logic              wd_sel,
  input  logic              we,
  input  logic [DATA_W-1:0] immediate,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] gppm_out,
  output logic              isZero
);

  logic [DATA_W-1:0] rf [REG_CNT];

  logic              s1_valid;
  logic [3:0]        s1_op;
  logic              s1_wd_sel;
  logic              s1_we;
  logic [AW-1:0]     s1_wa;
  logic [DATA_W-1:0] s1_imm;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;

  logic              advance;
  logic              fire;
  logic              accept;
  logic              s1_wr;
  logic [DATA_W-1:0] alu;
  logic [DATA_W-1:0] s1_wd;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [SW-1:0]     sh;

  assign advance     = !out_valid || out_ready;
  assign fire        = s1_valid && advance;
  assign instr_ready = !s1_valid || advance;
  assign accept      = instr_valid && instr_ready;
  assign s1_wr       = fire && s1_we && (s1_wa != '0);
  assign s1_wd       = s1_wd_sel ? alu : s1_imm;
  assign sh          = s1_b[SW-1:0];

  always_comb begin
    alu = '0;
    case (s1_op)
      4'd0:  alu = s1_a + s1_b;
      4'd1:  alu = s1_a - s1_b;
      4'd2:  alu = s1_a & s1_b;
      4'd3:  alu = s1_a | s1_b;
      4'd4:  alu = s1_a ^ s1_b;
      4'd5:  alu = ~(s1_a | s1_b);
      4'd6:  alu = {{(DATA_W-1){1'b0}},
                    $signed(s1_a) < $signed(s1_b)};
      4'd7:  alu = {{(DATA_W-1){1'b0}}, s1_a < s1_b};
      4'd8:  alu = s1_a << sh;
      4'd9:  alu = s1_a >> sh;
      4'd10: alu = $unsigned($signed(s1_a) >>> sh);
      4'd11: alu = s1_a;
      4'd12: alu = s1_b;
      default: alu = '0;
    endcase
  end

  // The instruction retiring on this edge forwards its write data so a
  // dependent instruction accepted on the same edge needs no bubble.
  always_comb begin
    op_a = '0;
    op_b = '0;
    if (ra1 != '0) op_a = rf[ra1];
    if (ra2 != '0) op_b = rf[ra2];
    if (s1_wr && s1_wa == ra1) op_a = s1_wd;
    if (s1_wr && s1_wa == ra2) op_b = s1_wd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_op     <= '0;
      s1_wd_sel <= 1'b0;
      s1_we     <= 1'b0;
      s1_wa     <= '0;
      s1_imm    <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
    end else if (advance || !s1_valid) begin
      s1_valid <= accept;
      if (accept) begin
        s1_op     <= operation;
        s1_wd_sel <= wd_sel;
        s1_we     <= we;
        s1_wa     <= wa;
        s1_imm    <= immediate;
        s1_a      <= op_a;
        s1_b      <= op_b;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      gppm_out  <= '0;
      isZero    <= 1'b0;
    end else if (fire) begin
      out_valid <= 1'b1;
      gppm_out  <= alu;
      isZero    <= (alu == '0);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) rf[i] <= '0;
    end else if (s1_wr) begin
      rf[s1_wa] <= s1_wd;
    end
  end

endmodule

// File: tb/tb_gppm_pipe.sv
// Directed self-checking bench for gppm_pipe.
// Hand-computed expectations checked with immediate assertions.
module tb_gppm_pipe;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [4:0]  wa;
  logic [3:0]  operation;
  logic        wd_sel;
  logic        we;
  logic [31:0] immediate;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] gppm_out;
  logic        isZero;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLT = 4'd6, SLTU = 4'd7;
  localparam logic [3:0] SRA = 4'd10, PA = 4'd11;

  gppm_pipe #(.DATA_W(32), .REG_CNT(32)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .ra1(ra1), .ra2(ra2), .wa(wa),
    .operation(operation), .wd_sel(wd_sel), .we(we),
    .immediate(immediate),
    .out_valid(out_valid), .out_ready(out_ready),
    .gppm_out(gppm_out), .isZero(isZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic out(input string tag, input logic [31:0] v);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".data"}, gppm_out, v);
    chk({tag, ".zero"}, {31'd0, isZero}, {31'd0, v == 32'd0});
  endtask

  task automatic drv(input logic [3:0] op, input logic [4:0] a,
                     input logic [4:0] b, input logic [4:0] w,
                     input logic e, input logic s, input logic [31:0] imm);
    instr_valid = 1'b1;
    operation   = op;
    ra1         = a;
    ra2         = b;
    wa          = w;
    we          = e;
    wd_sel      = s;
    immediate   = imm;
  endtask

  task automatic idle();
    instr_valid = 1'b0;
    we          = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    instr_valid = 1'b0;
    drv(PA, 0, 0, 0, 0, 0, 0);
    idle();
    tick();
    tick();
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.data", gppm_out, 32'd0);
    chk("rst.zero", {31'd0, isZero}, 32'd0);
    chk("rst.ready", {31'd0, instr_ready}, 32'd1);
    rst = 1'b0;

    drv(PA, 0, 0, 1, 1, 0, 32'd5);         tick();
    drv(PA, 0, 0, 2, 1, 0, 32'd7);         tick(); out("ld5", 0);
    drv(ADD, 1, 2, 3, 1, 1, 0);            tick(); out("ld7", 0);
    chk("chain.rdy0", {31'd0, instr_ready}, 32'd1);
    drv(ADD, 3, 3, 4, 1, 1, 0);            tick(); out("add", 12);
    chk("chain.rdy1", {31'd0, instr_ready}, 32'd1);
    drv(SUB, 4, 3, 5, 1, 1, 0);            tick(); out("dbl", 24);
    chk("chain.rdy2", {31'd0, instr_ready}, 32'd1);
    drv(SUB, 1, 1, 1, 1, 1, 0);            tick(); out("sub", 12);
    drv(SUB, 0, 2, 6, 1, 1, 0);            tick(); out("r1z", 0);
    drv(PA, 0, 0, 7, 1, 0, 32'd5);         tick(); out("neg", 32'hFFFF_FFF9);
    drv(SLT, 6, 7, 8, 1, 1, 0);            tick(); out("ld5b", 0);
    drv(SLTU, 6, 7, 9, 1, 1, 0);           tick(); out("slt", 1);
    drv(PA, 0, 0, 10, 1, 0, 32'h8000_0000); tick(); out("sltu", 0);
    drv(PA, 0, 0, 11, 1, 0, 32'd4);        tick(); out("ldmsb", 0);
    drv(SRA, 10, 11, 12, 1, 1, 0);         tick(); out("ld4", 0);
    drv(PA, 0, 0, 0, 1, 0, 32'd99);        tick(); out("sra", 32'hF800_0000);
    drv(PA, 0, 0, 13, 0, 0, 0);            tick(); out("wr0", 0);
    idle();                                tick(); out("rd0", 0);
    tick();
    chk("drain.valid", {31'd0, out_valid}, 32'd0);
    chk("drain.hold", gppm_out, 32'd0);

    out_ready = 1'b0;
    drv(PA, 3, 0, 14, 1, 0, 32'd55);       tick();
    chk("st.rdyA", {31'd0, instr_ready}, 32'd1);
    drv(PA, 4, 0, 15, 1, 0, 32'd77);       tick();
    drv(PA, 15, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      out("st.hold", 12);
      chk("st.rdy", {31'd0, instr_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("st.rel", {31'd0, instr_ready}, 32'd1);
    tick(); out("st.o2", 24);
    drv(PA, 14, 0, 0, 0, 0, 0);            tick(); out("st.o3", 77);
    idle();                                tick(); out("st.o4", 55);
    tick();

    out_ready = 1'b0;
    drv(PA, 4, 0, 16, 1, 0, 32'd123);      tick();
    drv(PA, 4, 0, 17, 1, 0, 32'd9);        tick();
    idle();
    out("mr.pre", 24);
    chk("mr.pre.rdy", {31'd0, instr_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("mr.valid", {31'd0, out_valid}, 32'd0);
    chk("mr.data", gppm_out, 32'd0);
    chk("mr.zero", {31'd0, isZero}, 32'd0);
    chk("mr.ready", {31'd0, instr_ready}, 32'd1);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    chk("mr.rel", {31'd0, out_valid}, 32'd0);
    drv(PA, 17, 0, 0, 0, 0, 0);            tick();
    drv(PA, 16, 0, 0, 0, 0, 0);            tick(); out("mr.r17", 0);
    drv(PA, 4, 0, 0, 0, 0, 0);             tick(); out("mr.r16", 0);
    drv(PA, 14, 0, 0, 0, 0, 0);            tick(); out("mr.r4", 0);
    idle();                                tick(); out("mr.r14", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
